byte_joining_ctrl: RTL
======================

BYTE_JOINING_CTRL -- requirements
Module: byte_joining_ctrl

Interface
REQ-001 The module SHALL have one clock and an asynchronous, active-high reset.
REQ-002 Port `clk1M`: input, 1 bit; byte-rate clock, 4x the lane word rate; all flops on its rising edge.
REQ-003 Port `reset`: input, 1 bit; asynchronous, active-high; forces every flop to its reset value immediately.
REQ-004 Port `enable`: input, 1 bit; 1 requests joining, 0 requests stop.
REQ-005 Port `lane_mode`: input, 2 bits; 00 = x1 (lane 0), 01 = x2 (lanes 0-1), 10 = x4 (lanes 0-3), 11 = reserved.
REQ-006 Port `lanes_valid`: input, 4 bits; bit i = 1 means the serial-to-parallel stage has a valid word on lane i.
REQ-007 Port `ctr_3`: output, 2 bits; lane-select code driven to the byte-joining mux.
REQ-008 Port `load`: output, 1 bit; one-cycle capture strobe for the lane holding registers.
REQ-009 Port `data_valid`: output, 1 bit; 1 while the mux output carries a valid joined byte.
REQ-010 Port `lane_err`: output, 1 bit; sticky flag, an active lane lost valid during RUN.
REQ-011 Port `cfg_err`: output, 1 bit; sticky flag, reserved lane_mode requested.
REQ-012 Port `state`: output, 2 bits; current FSM state code, for debug.
REQ-013 All outputs SHALL be registered; there SHALL be no combinational input-to-output path.

Function
REQ-014 The FSM SHALL have four states: IDLE = 00, ALIGN = 01, RUN = 10, ERROR = 11.
REQ-015 Active-lane count N SHALL be 1, 2 or 4 for lane_mode 00, 01, 10; the active mask SHALL be 0001, 0011 or 1111 respectively.
REQ-016 On entry to ALIGN, lane_mode SHALL be latched into an internal register; lane_mode changes outside IDLE SHALL be ignored.
REQ-017 IDLE -> ALIGN SHALL occur when enable = 1 and lane_mode != 11.
REQ-018 When in IDLE with enable = 1 and lane_mode = 11, the block SHALL stay in IDLE and set cfg_err.
REQ-019 cfg_err SHALL clear only on reset or on a successful IDLE -> ALIGN transition.
REQ-020 ALIGN -> RUN SHALL occur in the first cycle where (lanes_valid & mask) == mask; in that transition cycle load = 1 and the select counter = 0.
REQ-021 In RUN, ctr_3 SHALL equal the select counter, which increments by 1 every cycle and wraps to 0 after N-1.
- x1: ctr_3 is constant 0.
- x2: ctr_3 sequence is 0,1,0,1...
- x4: ctr_3 sequence is 0,1,2,3,0...
REQ-022 In RUN, load SHALL be 1 exactly in cycles where the counter equals N-1 (every cycle in x1), so new lane words appear when the counter wraps to 0.
REQ-023 data_valid SHALL be 1 in every RUN cycle starting from the cycle after the ALIGN -> RUN load, and 0 in all other states.
REQ-024 In RUN, if any active lanes_valid bit is 0 in a cycle, the next state SHALL be ERROR with lane_err = 1, load = 0 and data_valid = 0.
REQ-025 Inactive lanes_valid bits SHALL be ignored in every state.
REQ-026 ERROR SHALL hold ctr_3 = 0, load = 0 and data_valid = 0.
REQ-027 ERROR -> IDLE SHALL occur when enable = 0; lane_err SHALL remain 1 until the next IDLE -> ALIGN transition.
REQ-028 enable = 0 in ALIGN or RUN SHALL force IDLE on the next edge; load and data_valid SHALL drop in that same cycle, and a partially sequenced word is discarded.
REQ-029 In a cycle where enable = 0 and an active lane drops simultaneously in RUN, the block SHALL go to IDLE and SHALL NOT set lane_err.
REQ-030 In IDLE and ALIGN, ctr_3 = 0, load = 0 (except the REQ-020 transition cycle) and data_valid = 0.

Reset
REQ-031 On reset assertion, the block SHALL immediately force: state = IDLE, ctr_3 = 00, select counter = 0, load = 0, data_valid = 0, lane_err = 0, cfg_err = 0, latched mode = 10.
REQ-032 Reset asserted mid-RUN SHALL abort the sequence with no further load pulses.
REQ-033 After reset release, the first transition SHALL be evaluated at the next rising edge of clk1M.

Verification
REQ-034 x4 mode with all lanes valid and enable = 1 -> state sequence IDLE, ALIGN, RUN; ctr_3 = 0,1,2,3 repeating; load high when ctr_3 = 3; data_valid = 1 from the first RUN cycle.
REQ-035 x2 mode with lanes_valid = 0011 -> ctr_3 = 0,1,0,1; load every 2nd cycle; lanes 2-3 ignored.
REQ-036 x4 in RUN, lanes_valid drops to 1011 for one cycle -> next cycle state = 11, lane_err = 1, data_valid = 0; then enable = 0 -> IDLE with lane_err still 1; then enable = 1 -> lane_err = 0.
REQ-037 lane_mode = 11 with enable = 1 -> block stays in IDLE, cfg_err = 1; then lane_mode = 00 -> ALIGN, cfg_err = 0, ctr_3 held at 0 with load every cycle in RUN.
REQ-038 Reset asserted between clock edges mid-RUN (ctr_3 = 2) -> all outputs go to their reset values immediately, with no load pulse after release until ALIGN completes.
REQ-039 lane_mode changed 10 -> 01 during RUN -> sequence stays 0,1,2,3 until the block returns to IDLE.

Source files
------------

// File: rtl/byte_joining_ctrl.sv
// rtl/byte_joining_ctrl.sv - lane-to-byte joining sequencer for the deserializer datapath
//
// Purpose: steers the byte-joining mux across 1, 2 or 4 lanes and strobes the
// lane holding registers. It waits in ALIGN until every active lane has a
// valid word, then cycles the lane select while data is valid. It drops to
// ERROR if an active lane loses valid while running.
//
// Ports:
//   clk1M        in   byte-rate clock, all flops on its rising edge
//   reset        in   asynchronous active-high reset
//   enable       in   1 = join, 0 = stop (return to IDLE)
//   lane_mode    in   00 x1, 01 x2, 10 x4, 11 reserved (sampled in IDLE only)
//   lanes_valid  in   per-lane word-valid from the serial-to-parallel stage
//   ctr_3        out  lane-select code to the byte-joining mux
//   load         out  one-cycle capture strobe for the lane holding registers
//   data_valid   out  mux output carries a valid joined byte
//   lane_err     out  sticky: an active lane lost valid in RUN
//   cfg_err      out  sticky: reserved lane_mode requested
//   state        out  current FSM state code (debug)
//
// Every output comes straight from a flop. For that reason the load pulse that
// primes the holding registers appears in a final ALIGN cycle, the "armed"
// cycle marked by load_q. RUN then starts with counter 0 and data valid.

module byte_joining_ctrl (
    input  logic       clk1M,
    input  logic       reset,
    input  logic       enable,
    input  logic [1:0] lane_mode,
    input  logic [3:0] lanes_valid,
    output logic [1:0] ctr_3,
    output logic       load,
    output logic       data_valid,
    output logic       lane_err,
    output logic       cfg_err,
    output logic [1:0] state
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_ALIGN = 2'b01,
        ST_RUN   = 2'b10,
        ST_ERROR = 2'b11
    } state_t;

    state_t     state_q, state_d;
    logic [1:0] ctr_q, ctr_d;
    logic       load_q, load_d;
    logic       dv_q, dv_d;
    logic       lane_err_q, lane_err_d;
    logic       cfg_err_q, cfg_err_d;
    logic [1:0] mode_q, mode_d;

    logic [3:0] mask;
    logic [1:0] last;
    logic       all_valid;

    // Active lanes come from the latched mode only. This keeps a lane_mode change
    // outside IDLE from disturbing the sequence.
    always_comb begin
        mask = 4'b1111;
        last = 2'd3;
        case (mode_q)
            2'b00: begin mask = 4'b0001; last = 2'd0; end
            2'b01: begin mask = 4'b0011; last = 2'd1; end
            default: begin mask = 4'b1111; last = 2'd3; end
        endcase
    end

    assign all_valid = ((lanes_valid & mask) == mask);

    always_comb begin
        state_d    = state_q;
        ctr_d      = 2'd0;
        load_d     = 1'b0;
        dv_d       = 1'b0;
        lane_err_d = lane_err_q;
        cfg_err_d  = cfg_err_q;
        mode_d     = mode_q;
        case (state_q)
            ST_IDLE: begin
                if (enable) begin
                    if (lane_mode == 2'b11) begin
                        cfg_err_d = 1'b1;
                    end else begin
                        state_d    = ST_ALIGN;
                        mode_d     = lane_mode;
                        cfg_err_d  = 1'b0;
                        lane_err_d = 1'b0;
                    end
                end
            end
            ST_ALIGN: begin
                if (!enable) begin
                    state_d = ST_IDLE;
                end else if (load_q) begin
                    // Armed cycle done: lane words are captured, so RUN starts at select 0.
                    state_d = ST_RUN;
                    dv_d    = 1'b1;
                    load_d  = (last == 2'd0);
                end else if (all_valid) begin
                    load_d = 1'b1;
                end
            end
            ST_RUN: begin
                if (!enable) begin
                    // Disable wins over a simultaneous lane drop and sets no error.
                    state_d = ST_IDLE;
                end else if (!all_valid) begin
                    state_d    = ST_ERROR;
                    lane_err_d = 1'b1;
                end else begin
                    dv_d   = 1'b1;
                    ctr_d  = (ctr_q == last) ? 2'd0 : ctr_q + 2'd1;
                    load_d = ((ctr_q == last) ? 2'd0 : ctr_q + 2'd1) == last;
                end
            end
            ST_ERROR: begin
                if (!enable) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk1M or posedge reset) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            ctr_q      <= 2'd0;
            load_q     <= 1'b0;
            dv_q       <= 1'b0;
            lane_err_q <= 1'b0;
            cfg_err_q  <= 1'b0;
            mode_q     <= 2'b10;
        end else begin
            state_q    <= state_d;
            ctr_q      <= ctr_d;
            load_q     <= load_d;
            dv_q       <= dv_d;
            lane_err_q <= lane_err_d;
            cfg_err_q  <= cfg_err_d;
            mode_q     <= mode_d;
        end
    end

    assign ctr_3      = ctr_q;
    assign load       = load_q;
    assign data_valid = dv_q;
    assign lane_err   = lane_err_q;
    assign cfg_err    = cfg_err_q;
    assign state      = state_q;

endmodule
